// File: rtl/frame_mem_arbiter.sv
// Arbiter for the single-port ZBT frame memory shared by display, camera and processing.
// One access per cycle; read data is steered back to its owner through a tag pipeline.
`timescale 1ns/1ps
module frame_mem_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 36,
  parameter int READ_LAT   = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cam_en,
  input  logic              i_proc_en,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_grant,
  output logic              o_disp_rvalid,
  input  logic              i_cam_req,
  input  logic [ADDR_W-1:0] i_cam_addr,
  input  logic [DATA_W-1:0] i_cam_wdata,
  output logic              o_cam_grant,
  input  logic              i_proc_req,
  input  logic              i_proc_we,
  input  logic [ADDR_W-1:0] i_proc_addr,
  input  logic [DATA_W-1:0] i_proc_wdata,
  output logic              o_proc_grant,
  output logic              o_proc_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_PROC = 2'd2
  } tag_t;

  logic              w_d, w_c, w_p, w_promote;
  logic              w_disp_grant, w_cam_grant, w_proc_grant;
  tag_t              w_tag_in;
  logic [SW-1:0]     r_starve;
  tag_t              r_tag [READ_LAT+1];
  logic              r_disp_rvalid, r_proc_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;

  // Grants are forced low while reset is held so nothing is accepted during reset.
  always_comb begin
    w_d          = i_disp_req & i_rst_n;
    w_c          = i_cam_req & i_cam_en & i_rst_n;
    w_p          = i_proc_req & i_proc_en & i_rst_n;
    w_promote    = (r_starve == SW'(STARVE_MAX));
    w_disp_grant = w_d;
    w_proc_grant = w_p & ~w_d & (w_promote | ~w_c);
    w_cam_grant  = w_c & ~w_d & ~(w_promote & w_p);
    w_tag_in     = TAG_NONE;
    if (w_disp_grant)
      w_tag_in = TAG_DISP;
    else if (w_proc_grant && !i_proc_we)
      w_tag_in = TAG_PROC;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve <= '0;
    end else if (!w_p || w_proc_grant) begin
      r_starve <= '0;
    end else if (!w_promote) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_disp_grant) begin
        r_mem_addr <= i_disp_addr;
      end else if (w_cam_grant) begin
        r_mem_addr  <= i_cam_addr;
        r_mem_we    <= 1'b1;
        r_mem_wdata <= i_cam_wdata;
      end else if (w_proc_grant) begin
        r_mem_addr  <= i_proc_addr;
        r_mem_we    <= i_proc_we;
        r_mem_wdata <= i_proc_wdata;
      end
    end
  end

  // Stage READ_LAT lines up with the cycle mem_rdata is valid for that access.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= READ_LAT; i++) r_tag[i] <= TAG_NONE;
      r_disp_rvalid <= 1'b0;
      r_proc_rvalid <= 1'b0;
      r_rdata       <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i <= READ_LAT; i++) r_tag[i] <= r_tag[i-1];
      r_disp_rvalid <= (r_tag[READ_LAT] == TAG_DISP);
      r_proc_rvalid <= (r_tag[READ_LAT] == TAG_PROC);
      if (r_tag[READ_LAT] != TAG_NONE) r_rdata <= i_mem_rdata;
    end
  end

  assign o_disp_grant  = w_disp_grant;
  assign o_cam_grant   = w_cam_grant;
  assign o_proc_grant  = w_proc_grant;
  assign o_disp_rvalid = r_disp_rvalid;
  assign o_proc_rvalid = r_proc_rvalid;
  assign o_rdata       = r_rdata;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_we      = r_mem_we;
  assign o_mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_frame_mem_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 36;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cam_en = 1'b0, proc_en = 1'b0;
  logic              disp_req = 1'b0, cam_req = 1'b0, proc_req = 1'b0, proc_we = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0, cam_addr = '0, proc_addr = '0;
  logic [DATA_W-1:0] cam_wdata = '0, proc_wdata = '0, mem_rdata = '0;
  logic              disp_grant, cam_grant, proc_grant, disp_rvalid, proc_rvalid, mem_we;
  logic [DATA_W-1:0] rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_a, cnt_b;

  frame_mem_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cam_en(cam_en), .i_proc_en(proc_en),
    .i_disp_req(disp_req), .i_disp_addr(disp_addr), .o_disp_grant(disp_grant),
    .o_disp_rvalid(disp_rvalid), .i_cam_req(cam_req), .i_cam_addr(cam_addr),
    .i_cam_wdata(cam_wdata), .o_cam_grant(cam_grant), .i_proc_req(proc_req),
    .i_proc_we(proc_we), .i_proc_addr(proc_addr), .i_proc_wdata(proc_wdata),
    .o_proc_grant(proc_grant), .o_proc_rvalid(proc_rvalid), .o_rdata(rdata),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle's drive point, then to its sample point.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #2;
    check_eq("rst_disp_grant", disp_grant, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_rvalids", {disp_rvalid, proc_rvalid}, 0);
    next_cycle(); rst_n = 1'b1;
    next_cycle();

    // Single display read: grant at T, mem at T+1, data at T+3, rvalid at T+4 only
    disp_req = 1; disp_addr = 19'h00123;
    sample();
    check_eq("disp_grant_T", {disp_grant, cam_grant, proc_grant}, 3'b100);
    next_cycle(); disp_req = 0;
    sample();
    check_eq("disp_mem_addr", mem_addr, 19'h00123);
    check_eq("disp_mem_we", mem_we, 0);
    next_cycle(); sample();
    check_eq("disp_rvalid_T2", disp_rvalid, 0);
    next_cycle(); mem_rdata = 36'h5A5A5A5A5;
    sample();
    check_eq("disp_rvalid_T3", disp_rvalid, 0);
    next_cycle(); mem_rdata = 36'h0;
    sample();
    check_eq("disp_rvalid_T4", disp_rvalid, 1);
    check_eq("disp_rdata_T4", rdata, 36'h5A5A5A5A5);
    check_eq("proc_rvalid_T4", proc_rvalid, 0);
    next_cycle(); sample();
    check_eq("disp_rvalid_T5", disp_rvalid, 0);
    check_eq("rdata_hold", rdata, 36'h5A5A5A5A5);

    // Three-way contention
    next_cycle();
    cam_en = 1; proc_en = 1;
    disp_req = 1; disp_addr = 19'h00400;
    cam_req = 1;  cam_addr = 19'h11111; cam_wdata = 36'hC0FFEE123;
    proc_req = 1; proc_we = 1; proc_addr = 19'h22222; proc_wdata = 36'hABCDE0123;
    sample();
    check_eq("cont3_grants", {disp_grant, cam_grant, proc_grant}, 3'b100);
    next_cycle(); disp_req = 0;
    sample();
    check_eq("cont2_grants", {disp_grant, cam_grant, proc_grant}, 3'b010);
    next_cycle(); cam_req = 0;
    sample();
    check_eq("cam_mem_we", mem_we, 1);
    check_eq("cam_mem_addr", mem_addr, 19'h11111);
    check_eq("cam_mem_wdata", mem_wdata, 36'hC0FFEE123);
    check_eq("proc_alone_grant", {disp_grant, cam_grant, proc_grant}, 3'b001);
    next_cycle(); proc_req = 0;
    sample();
    check_eq("proc_wr_mem_we", mem_we, 1);
    check_eq("proc_wr_mem_wdata", mem_wdata, 36'hABCDE0123);
    next_cycle(); sample();
    check_eq("idle_mem_we", mem_we, 0);
    check_eq("idle_mem_addr_hold", mem_addr, 19'h22222);

    // Starvation: cam 8 cycles, proc on the 9th, then cam again
    next_cycle();
    cam_req = 1; proc_req = 1; proc_we = 1;
    cnt_a = 0;
    for (int i = 0; i < 8; i++) begin
      sample();
      if (cam_grant && !proc_grant) cnt_a++;
      next_cycle();
    end
    check_eq("starve_cam_cycles", cnt_a, 8);
    sample();
    check_eq("starve_proc_grant", {cam_grant, proc_grant}, 2'b01);
    next_cycle(); sample();
    check_eq("starve_cam_again", {cam_grant, proc_grant}, 2'b10);
    check_eq("starve_cleared", dut.r_starve, 0);
    next_cycle(); cam_req = 0; proc_req = 0;

    // Enable gating
    next_cycle();
    proc_en = 0; proc_req = 1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (proc_grant) cnt_a++;
      if (dut.r_starve != 0) cnt_b++;
      next_cycle();
    end
    check_eq("gated_no_grant", cnt_a, 0);
    check_eq("gated_starve_zero", cnt_b, 0);
    proc_en = 1;
    sample();
    check_eq("gated_enable_grant", proc_grant, 1);
    next_cycle(); proc_req = 0;

    // Interleaved: disp read T, proc read T+1, proc write T+2
    next_cycle();
    disp_req = 1; disp_addr = 19'h00AAA;
    sample();
    check_eq("il_disp_grant", disp_grant, 1);
    next_cycle();
    disp_req = 0; proc_req = 1; proc_we = 0; proc_addr = 19'h00BBB;
    sample();
    check_eq("il_proc_rd_grant", proc_grant, 1);
    next_cycle();
    proc_we = 1; proc_addr = 19'h00CCC; proc_wdata = 36'h123456789;
    sample();
    check_eq("il_proc_wr_grant", proc_grant, 1);
    check_eq("il_rd_mem_addr", mem_addr, 19'h00BBB);
    check_eq("il_rd_mem_we", mem_we, 0);
    next_cycle();
    proc_req = 0; mem_rdata = 36'h111111111;
    sample();
    check_eq("il_wr_mem_we", mem_we, 1);
    next_cycle(); mem_rdata = 36'h222222222;
    sample();
    check_eq("il_disp_rvalid", {disp_rvalid, proc_rvalid}, 2'b10);
    check_eq("il_disp_rdata", rdata, 36'h111111111);
    next_cycle(); mem_rdata = 36'h333333333;
    sample();
    check_eq("il_proc_rvalid", {disp_rvalid, proc_rvalid}, 2'b01);
    check_eq("il_proc_rdata", rdata, 36'h222222222);
    next_cycle(); mem_rdata = 36'h0;
    sample();
    check_eq("il_no_rvalid", {disp_rvalid, proc_rvalid}, 2'b00);
    check_eq("il_rdata_hold", rdata, 36'h222222222);

    // Reset with two proc reads in flight
    next_cycle();
    proc_req = 1; proc_we = 0; proc_addr = 19'h01234;
    next_cycle(); proc_addr = 19'h05678;
    next_cycle(); proc_req = 0;
    #2 rst_n = 0;
    #1;
    check_eq("mid_rst_mem_addr", mem_addr, 0);
    check_eq("mid_rst_rdata", rdata, 0);
    check_eq("mid_rst_outs", {mem_we, disp_rvalid, proc_rvalid, disp_grant, cam_grant, proc_grant}, 0);
    next_cycle(); next_cycle();
    rst_n = 1;
    mem_rdata = 36'hFFFFFFFFF;
    cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (proc_rvalid) cnt_a++;
      next_cycle();
    end
    check_eq("post_rst_no_rvalid", cnt_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_mem_arbiter.md
Name: frame_mem_arbiter

Overview:
- Shares the single-port ZBT frame memory between three requesters: VGA display reader, camera pixel writer, and the processing engines (blur / edge detection).
- Sits between the top-level pipeline and the ZBT driver.
- The main sequencing FSM gates which requesters are live through the enable inputs.
- Issues one memory access per cycle and routes read data back to the issuing requester after the fixed memory latency.

Parameters:
ADDR_W, 19, memory word address width
DATA_W, 36, memory data width
READ_LAT, 2, cycles from address presented on mem_* to valid mem_rdata
STARVE_MAX, 8, consecutive denied cycles before proc is promoted above cam

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cam_en  input  1  camera requester enabled (view-finder states)
proc_en  input  1  processing requester enabled (blur/edge states)
disp_req  input  1  display read request
disp_addr  input  ADDR_W  display read address
disp_grant  output  1  display access accepted this cycle
disp_rvalid  output  1  rdata belongs to display this cycle
cam_req  input  1  camera write request
cam_addr  input  ADDR_W  camera write address
cam_wdata  input  DATA_W  camera write data
cam_grant  output  1  camera access accepted this cycle
proc_req  input  1  processing access request
proc_we  input  1  1 = write, 0 = read
proc_addr  input  ADDR_W  processing address
proc_wdata  input  DATA_W  processing write data
proc_grant  output  1  processing access accepted this cycle
proc_rvalid  output  1  rdata belongs to proc this cycle
rdata  output  DATA_W  registered copy of mem_rdata
mem_addr  output  ADDR_W  ZBT address (registered)
mem_we  output  1  ZBT write enable (registered)
mem_wdata  output  DATA_W  ZBT write data (registered)
mem_rdata  input  DATA_W  ZBT read data

Behaviour:
- Reset (rst_n low, asynchronous): all grants/rvalids 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata 0, starve counter 0, tag pipeline cleared to NONE.
- Reset takes effect immediately. In-flight reads are dropped and no rvalid is produced for them after release.
- Effective requests: d = disp_req; c = cam_req & cam_en; p = proc_req & proc_en. A disabled requester is never granted.
- Grants are combinational from effective requests and the starve counter. At most one grant is high per cycle.
- Normal priority: display > cam > proc.
- Promoted priority: when starve counter == STARVE_MAX, priority is display > proc > cam. Display is never pre-empted.
- Handshake: the requester holds req/addr/data stable until it sees grant high. The access is accepted in the cycle grant = 1. The requester may present a new access the next cycle.
- Grant cycle T: mem_addr/mem_we/mem_wdata are registered from the winner and appear at T+1.
  - Display: mem_we = 0.
  - Camera: mem_we = 1.
  - Proc: mem_we = proc_we.
- No grant in cycle T: mem_we = 0 at T+1. mem_addr and mem_wdata hold their previous values.
- Read return:
  - A 2-bit owner tag (NONE / DISP / PROC) enters a shift register on each read grant; writes enter NONE.
  - mem_rdata is valid at T+1+READ_LAT.
  - rdata is registered from it, and the matching rvalid pulses for one cycle at T+2+READ_LAT.
  - Total grant-to-rvalid latency is READ_LAT+2 (4 at default).
- Back-to-back reads from any mix of owners return in grant order, one per cycle, with no bubbles.
- Starve counter:
  - Increments each cycle p = 1 and proc_grant = 0, saturating at STARVE_MAX.
  - Cleared on proc_grant or when p = 0 (including proc_en low).
- Simultaneous events:
  - Display requesting every cycle starves both others indefinitely. This is by design, since display is real-time.
  - The counter still saturates and holds.
- rdata holds its last value when no rvalid is asserted.

Test Plan:
- Reset: assert rst_n=0 mid-stream with two proc reads in flight → outputs immediately 0. After release, no proc_rvalid within 10 cycles.
- Single display read: disp_req=1, disp_addr=0x00123 at T → disp_grant=1 at T; mem_addr=0x00123, mem_we=0 at T+1. mem_rdata=0x5A5A5A5A5 driven at T+3 → rdata=0x5A5A5A5A5, disp_rvalid=1 at T+4 only.
- Three-way contention, one cycle: all req=1, cam_en=proc_en=1 → disp_grant only. With disp_req dropped next cycle → cam_grant, mem_we=1, mem_wdata=cam_wdata.
- Starvation, STARVE_MAX=8: cam_req and proc_req held high continuously, disp idle → cam granted 8 cycles, then proc_grant in cycle 9 with counter cleared, then cam again.
- Enable gating: proc_en=0 with proc_req=1 for 20 cycles → no proc_grant and counter stays 0. proc_en=1 → proc_grant next cycle.
- Interleaved reads: disp read at T, proc read at T+1, proc write at T+2 → disp_rvalid at T+4, proc_rvalid at T+5, no rvalid at T+6, data matching the respective mem_rdata cycles.
